// File: rtl/pdpm_axis_pkt_bridge.sv
// Byte-to-word AXI-Stream packet bridge with store-and-forward FIFO.
// Only complete good frames are released; bad or overflowing frames drop.
module pdpm_axis_pkt_bridge #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16,
  localparam int KEEP_W = DATA_W / 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int IDX_W  = $clog2(KEEP_W)
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic [ADDR_W:0]   fifo_level
);

  localparam int MW = 1 + KEEP_W + DATA_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(KEEP_W - 1);
  localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_RECV, S_DROP} st_t;

  st_t st_q, st_d;
  logic rdy_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W:0]   wr_q, wr_d, cm_q, cm_d, rd_q, fp_q;
  logic [CNT_W-1:0]  pkt_q, pkt_d, drop_q, drop_d;
  logic              ov_q, ol_q;
  logic [DATA_W-1:0] od_q;
  logic [KEEP_W-1:0] ok_q;
  logic [MW-1:0]     mem [DEPTH];
  logic [MW-1:0]     wdat;
  logic              we, acc, full, word_end;
  logic              fetch, take;
  logic [DATA_W-1:0] lane_data;
  logic [KEEP_W-1:0] lane_keep;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign s_axis_tready = rdy_q;
  assign acc       = s_axis_tvalid & rdy_q;
  assign full      = (wr_q - rd_q) == FULL_LVL;
  assign word_end  = (idx_q == IDX_MAX) | s_axis_tlast;
  assign lane_data = data_q
                   | (DATA_W'(s_axis_tdata) << {idx_q, 3'b000});
  assign lane_keep = keep_q | (KEEP_W'(1) << idx_q);
  assign wdat      = {s_axis_tlast, lane_keep, lane_data};

  always_comb begin
    st_d   = st_q;
    data_d = data_q;
    keep_d = keep_q;
    idx_d  = idx_q;
    wr_d   = wr_q;
    cm_d   = cm_q;
    pkt_d  = pkt_q;
    drop_d = drop_q;
    we     = 1'b0;
    if (acc) begin
      unique case (st_q)
        S_RECV: begin
          data_d = lane_data;
          keep_d = lane_keep;
          idx_d  = idx_q + 1'b1;
          if (word_end) begin
            data_d = '0;
            keep_d = '0;
            idx_d  = '0;
            if (full) begin
              wr_d = cm_q;
              // overflow on the final word needs no discard phase
              if (s_axis_tlast) drop_d = sat(drop_q);
              else st_d = S_DROP;
            end else if (s_axis_tlast && s_axis_tuser) begin
              wr_d   = cm_q;
              drop_d = sat(drop_q);
            end else begin
              we   = 1'b1;
              wr_d = wr_q + 1'b1;
              if (s_axis_tlast) begin
                cm_d  = wr_q + 1'b1;
                pkt_d = sat(pkt_q);
              end
            end
          end
        end
        S_DROP: begin
          if (s_axis_tlast) begin
            drop_d = sat(drop_q);
            st_d   = S_RECV;
          end
        end
        default: st_d = S_RECV;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      st_q   <= S_RECV;
      rdy_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      idx_q  <= '0;
      wr_q   <= '0;
      cm_q   <= '0;
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      st_q   <= st_d;
      rdy_q  <= 1'b1;
      data_q <= data_d;
      keep_q <= keep_d;
      idx_q  <= idx_d;
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      pkt_q  <= pkt_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (we) mem[wr_q[ADDR_W-1:0]] <= wdat;
  end

  // slots are freed on acceptance, so the output word still counts as held
  assign take  = ov_q & m_axis_tready;
  assign fetch = (fp_q != cm_q) & (~ov_q | m_axis_tready);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      fp_q <= '0;
      rd_q <= '0;
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      ok_q <= '0;
      od_q <= '0;
    end else begin
      if (take) rd_q <= rd_q + 1'b1;
      if (fetch) begin
        fp_q <= fp_q + 1'b1;
        ov_q <= 1'b1;
        {ol_q, ok_q, od_q} <= mem[fp_q[ADDR_W-1:0]];
      end else if (take) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = od_q;
  assign m_axis_tkeep  = ok_q;
  assign m_axis_tvalid = ov_q;
  assign m_axis_tlast  = ol_q;
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
  assign fifo_level    = wr_q - rd_q;

endmodule

// File: tb/tb_pdpm_axis_pkt_bridge.sv
// Directed bench for pdpm_axis_pkt_bridge at DATA_W=64, DEPTH=16.
// Frame table plus backpressure and mid-frame reset sequences.
module tb_pdpm_axis_pkt_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic [15:0] pkt_cnt, drop_cnt;
  logic [4:0]  level;

  int total = 0;
  int bad = 0;

  pdpm_axis_pkt_bridge #(.DATA_W(64), .DEPTH(16), .CNT_W(16)) dut (
    .axis_aclk(clk),
    .axis_aresetn(rst_n),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .pkt_count(pkt_cnt),
    .drop_count(drop_cnt),
    .fifo_level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;
  beat_t q[$];

  always @(negedge clk)
    if (rst_n && m_tvalid && m_tready)
      q.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast});

  typedef struct {
    int          len;
    logic [7:0]  base;
    logic        bad;
    int          words;
    logic [7:0]  lastkeep;
    int          dpkt;
    int          ddrop;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int len, input logic [7:0] base,
                            input logic b);
    for (int i = 0; i < len; i++) begin
      s_tdata  = 8'(base + 8'(i));
      s_tvalid = 1'b1;
      s_tlast  = (i == len - 1);
      s_tuser  = b && (i == len - 1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  function automatic logic [63:0] kmask(input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (k[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  vec_t vt[6];

  initial begin
    int p0, d0, n, nl, r;
    logic [63:0] ed;
    logic [7:0]  ek;

    vt[0] = '{len:1,   base:8'hA5, bad:0, words:1, lastkeep:8'h01,
              dpkt:1, ddrop:0};
    vt[1] = '{len:20,  base:8'h00, bad:0, words:3, lastkeep:8'h0F,
              dpkt:1, ddrop:0};
    vt[2] = '{len:64,  base:8'h20, bad:1, words:0, lastkeep:8'h00,
              dpkt:0, ddrop:1};
    vt[3] = '{len:8,   base:8'h40, bad:0, words:1, lastkeep:8'hFF,
              dpkt:1, ddrop:0};
    vt[4] = '{len:200, base:8'h00, bad:0, words:0, lastkeep:8'h00,
              dpkt:0, ddrop:1};
    vt[5] = '{len:9,   base:8'h60, bad:0, words:2, lastkeep:8'h01,
              dpkt:1, ddrop:0};

    #12;
    chk("rst_tready", 64'(s_tready), 0);
    chk("rst_tvalid", 64'(m_tvalid), 0);
    chk("rst_tlast", 64'(m_tlast), 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", 64'(m_tkeep), 0);
    chk("rst_pkt", 64'(pkt_cnt), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    chk("rst_level", 64'(level), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("tready_on", 64'(s_tready), 1);

    for (int v = 0; v < 6; v++) begin
      q.delete();
      p0 = pkt_cnt;
      d0 = drop_cnt;
      send_frame(vt[v].len, vt[v].base, vt[v].bad);
      repeat (10) @(posedge clk);
      #1;
      chk($sformatf("v%0d_words", v), 64'(q.size()), 64'(vt[v].words));
      n = (q.size() < vt[v].words) ? q.size() : vt[v].words;
      for (int w = 0; w < n; w++) begin
        ed = '0;
        for (int l = 0; l < 8; l++)
          if (w * 8 + l < vt[v].len)
            ed[l*8 +: 8] = 8'(vt[v].base + 8'(w * 8 + l));
        ek = (w == vt[v].words - 1) ? vt[v].lastkeep : 8'hFF;
        chk($sformatf("v%0d_w%0d_keep", v, w), 64'(q[w].k), 64'(ek));
        chk($sformatf("v%0d_w%0d_data", v, w), q[w].d & kmask(ek), ed);
        chk($sformatf("v%0d_w%0d_last", v, w), 64'(q[w].l),
            64'(w == vt[v].words - 1));
      end
      chk($sformatf("v%0d_pkt", v), 64'(pkt_cnt), 64'(p0 + vt[v].dpkt));
      chk($sformatf("v%0d_drop", v), 64'(drop_cnt),
          64'(d0 + vt[v].ddrop));
      chk($sformatf("v%0d_level", v), 64'(level), 0);
    end

    // downstream stalled until the FIFO is exactly full
    q.delete();
    m_tready = 1'b0;
    p0 = pkt_cnt;
    d0 = drop_cnt;
    send_frame(64, 8'h10, 1'b0);
    send_frame(64, 8'h80, 1'b0);
    send_frame(8, 8'hC0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_level", 64'(level), 16);
    chk("bp_tvalid", 64'(m_tvalid), 1);
    chk("bp_pkt", 64'(pkt_cnt), 64'(p0 + 2));
    chk("bp_drop", 64'(drop_cnt), 64'(d0 + 1));
    chk("bp_hold_data", m_tdata, 64'h1716151413121110);
    m_tready = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("bp_rate_words", 64'(q.size()), 16);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_words", 64'(q.size()), 16);
    nl = 0;
    foreach (q[i]) nl += q[i].l;
    chk("bp_lasts", 64'(nl), 2);
    if (q.size() >= 16) begin
      chk("bp_w0", q[0].d, 64'h1716151413121110);
      chk("bp_w7_last", 64'(q[7].l), 1);
      chk("bp_w8", q[8].d, 64'h8786858483828180);
      chk("bp_w15", q[15].d, 64'hBFBEBDBCBBBAB9B8);
    end
    chk("bp_level_end", 64'(level), 0);

    // reset mid-frame with one frame buffered
    q.delete();
    m_tready = 1'b0;
    send_frame(8, 8'h30, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      s_tdata  = 8'(8'h90 + 8'(i));
      s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    chk("pre_rst_tvalid", 64'(m_tvalid), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(m_tvalid), 0);
    chk("arst_tdata", m_tdata, 0);
    chk("arst_tkeep", 64'(m_tkeep), 0);
    chk("arst_tlast", 64'(m_tlast), 0);
    chk("arst_tready", 64'(s_tready), 0);
    chk("arst_pkt", 64'(pkt_cnt), 0);
    chk("arst_level", 64'(level), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_frame(3, 8'h50, 1'b0);
    r = 0;
    while (q.size() == 0 && r < 20) begin
      @(posedge clk); #1;
      r++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("post_words", 64'(q.size()), 1);
    if (q.size() >= 1) begin
      chk("post_keep", 64'(q[0].k), 64'h07);
      chk("post_data", q[0].d & kmask(8'h07), 64'h525150);
      chk("post_last", 64'(q[0].l), 1);
    end
    chk("post_pkt", 64'(pkt_cnt), 1);
    chk("post_drop", 64'(drop_cnt), 0);
    chk("post_level", 64'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
